instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Owns the architectural PC register and consumes next_pc from the PC controller.
//  Issues instruction-memory reads and tracks one outstanding request.
//  Buffers returned words with their PC in a small FIFO and presents them to decode through a valid/ready handshake.
//  On a jump, branch or trap it discards stale fetch state (in-flight request and buffered words).
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  FIFO_DEPTH  2              fetch-buffer entries, power of two, >= 2
// PORTS
//  clk             in   1   clock, rising edge
//  reset           in   1   synchronous, active-high reset
//  next_pc         in   32  next PC from PC controller (pc+4, jump, branch or trap target)
//  redirect        in   1   next_pc is non-sequential (jump | branch_taken | trapped)
//  pc_stall        in   1   hold PC, issue no new request
//  pc              out  32  current fetch PC, fed back to PC controller
//  imem_req_valid  out  1   read request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_req_addr   out  32  word address {pc[31:2],2'b00}
//  imem_resp_valid in   1   read data valid (exactly one per accepted request)
//  imem_resp_data  in   32  instruction word
//  if_valid        out  1   buffered instruction available to decode
//  if_ready        in   1   decode consumes head this cycle
//  if_pc           out  32  PC of head entry
//  if_instr        out  32  instruction of head entry
//  if_misaligned   out  1   head entry is a misaligned-fetch fault
// BEHAVIOUR
//  Reset values:
//   - pc=RESET_PC, state=S_REQ, FIFO empty.
//   - imem_req_valid=0, if_valid=0, if_pc=0, if_instr=0, if_misaligned=0.
//   - reset mid-transaction: any later response is ignored (state S_REQ, not S_WAIT).
//  Request issue:
//   - imem_req_valid = (state==S_REQ) & !pc_stall & (fifo_count < FIFO_DEPTH).
//   - req_fire = imem_req_valid & imem_req_ready.
//  PC update, in priority order:
//   1. redirect: pc <= next_pc. Overrides pc_stall.
//   2. else req_fire: pc <= next_pc.
//   3. else: hold.
//   - The PC of an issued request is latched into req_pc on req_fire.
//  State machine (encodings in fetch_defines.vh):
//   - S_REQ:   req_fire & !redirect -> S_WAIT.  req_fire & redirect -> S_DRAIN.  Otherwise stay.
//   - S_WAIT:  resp_valid & !redirect -> push {req_pc, resp_data, 0}, then S_REQ.
//              resp_valid & redirect -> discard response, S_REQ.
//              !resp_valid & redirect -> S_DRAIN.
//   - S_DRAIN: resp_valid -> discard response, S_REQ. A redirect here stays in S_DRAIN.
//   - Throughput: one fetch per 2 cycles. Latency: req_fire at N, resp at N+1, if_valid at N+2.
//  FIFO:
//   - Push and pop in the same cycle are legal, including when the FIFO is full.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - redirect clears the FIFO in the same cycle. if_valid is forced 0 that cycle, so no pop occurs.
//   - if_valid = !empty & !redirect. Head outputs are 0 when empty.
//   - Full: no request is issued. At most one request is in flight, so a response never overflows the FIFO.
// CONFIGURATION
//  Macro FETCH_MISALIGN_CHECK_EN:
//   - Defined: in S_REQ with pc[1:0]!=0 and FIFO space, no memory request is made.
//     Push {pc, 32'h0000_0013 (NOP), 1} and stay in S_REQ.
//     pc holds until redirect (the trap unit supplies it).
//   - Undefined: pc[1:0] is ignored, the address is always word-aligned, and if_misaligned is tied 0.
//     The port exists in both builds.
// STRUCTURE
//  fetch_defines.vh (shared header):
//   - state encodings S_REQ=2'd0, S_WAIT=2'd1, S_DRAIN=2'd2
//   - NOP_INSTR=32'h0000_0013
//   - FETCH_ENTRY_W=65 (pc, instr, misaligned flag)
//  Sub-module fetch_fifo:
//   - parameters WIDTH, DEPTH
//   - ports clk, reset, flush, push, push_data, pop, pop_data, empty, full, count
//  Top level: PC register, FSM, req_pc register, output muxing.
// TESTING
//  1. Reset, imem_req_ready=1, resp one cycle later, if_ready=1, next_pc=pc+4
//     -> if_pc sequence 0,4,8,C; if_instr equals memory words.
//  2. if_ready=0 for 10 cycles
//     -> FIFO fills at 2 entries; imem_req_valid=0; pc=8; no entry lost after if_ready=1.
//  3. pc_stall=1 for 5 cycles at pc=0x10
//     -> no req_fire, pc stays 0x10; fetch resumes at 0x10.
//  4. Redirect to 0xDEAD0000 while in S_WAIT for pc=0x20 (resp arrives next cycle)
//     -> that response is discarded, FIFO flushed, next if_pc=0xDEAD0000.
//  5. Redirect coincident with resp_valid, and redirect coincident with req_fire
//     -> no stale entry, no double-discard; next if_pc equals redirect target.
//  6. With FETCH_MISALIGN_CHECK_EN, redirect to 0xCAFEBABE
//     -> no imem request; if_pc=0xCAFEBABE, if_instr=0x13, if_misaligned=1.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state encodings,
// the NOP used for misaligned-fetch faults, and the layout of a fetch-buffer entry.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam int          FETCH_ENTRY_W = 65;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } fetch_entry_t;

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// fetch_fifo: small power-of-two FIFO holding fetched {pc, instr, misaligned} entries.
// Supports simultaneous push/pop (also when full) and a single-cycle flush.
module fetch_fifo
  import instruction_fetch_unit_pkg::*;
#(
  parameter int WIDTH = FETCH_ENTRY_W,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign do_pop   = pop & ~empty & ~flush;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still legal.
  assign do_push  = push & ~flush & (~full | do_pop);
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC register, one-outstanding-request fetch FSM and fetch buffer.
// Optional misaligned-fetch fault generation is enabled by defining FETCH_MISALIGN_CHECK_EN.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic        pc_stall,
  output logic [31:0] pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_misaligned
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             req_valid, req_fire;
  logic             resp_push, misalign_push, pc_aligned;
  logic             fifo_empty, fifo_full, fifo_space, fifo_pop;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     push_entry, head_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic MISALIGN_EN = 1'b1;
  logic misalign_sent_q, misalign_sent_d;

  // A misaligned PC yields exactly one fault entry; the trap unit must redirect us away.
  assign pc_aligned    = (pc_q[1:0] == 2'b00);
  assign misalign_push = ~reset & (state_q == S_REQ) & ~pc_aligned & ~pc_stall &
                         ~redirect & fifo_space & ~misalign_sent_q;

  always_comb begin
    misalign_sent_d = misalign_sent_q | misalign_push;
    if (redirect) misalign_sent_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) misalign_sent_q <= 1'b0;
    else       misalign_sent_q <= misalign_sent_d;
  end
`else
  localparam logic MISALIGN_EN = 1'b0;
  assign pc_aligned    = 1'b1;
  assign misalign_push = 1'b0;
`endif

  assign fifo_space = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign req_valid  = ~reset & (state_q == S_REQ) & ~pc_stall & fifo_space & pc_aligned;
  assign req_fire   = req_valid & imem_req_ready;
  assign resp_push  = (state_q == S_WAIT) & imem_resp_valid & ~redirect & ~fifo_full;
  assign fifo_pop   = if_valid & if_ready;

  always_comb begin
    push_entry = '0;
    if (misalign_push) begin
      push_entry.pc         = pc_q;
      push_entry.instr      = NOP_INSTR;
      push_entry.misaligned = 1'b1;
    end else begin
      push_entry.pc         = req_pc_q;
      push_entry.instr      = imem_resp_data;
      push_entry.misaligned = 1'b0;
    end
  end

  // Redirect wins over stall; otherwise the PC only advances when memory takes the request.
  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (redirect || req_fire) pc_d = next_pc;
    if (req_fire) req_pc_d = pc_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:   if (req_fire) state_d = redirect ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (imem_resp_valid) state_d = S_REQ;
        else if (redirect)   state_d = S_DRAIN;
      end
      S_DRAIN: if (imem_resp_valid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (resp_push | misalign_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign pc             = pc_q;
  assign imem_req_valid = req_valid;
  assign imem_req_addr  = word_addr(pc_q);
  assign if_valid       = ~reset & ~fifo_empty & ~redirect;
  assign if_pc          = head_entry.pc;
  assign if_instr       = head_entry.instr;
  assign if_misaligned  = MISALIGN_EN & head_entry.misaligned;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: memory responder, PC-controller model
// and a scoreboard of the expected instruction stream consumed by decode.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_pc;
  logic        redirect;
  logic [31:0] redir_target;
  logic        pc_stall;
  logic [31:0] pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_misaligned;

  int tests_run    = 0;
  int tests_failed = 0;
  int pop_count    = 0;
  int extra_delay  = 0;
  int resp_cnt     = 0;
  logic [31:0] resp_addr = '0;
  fetch_entry_t expq[$];

  always #5 clk = ~clk;

  // PC controller: sequential pc+4 unless a redirect is presented.
  assign next_pc = redirect ? redir_target : pc + 32'd4;

  instruction_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .next_pc         (next_pc),
    .redirect        (redirect),
    .pc_stall        (pc_stall),
    .pc              (pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_misaligned   (if_misaligned)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h1357_9BDF;
  endfunction

  function automatic void set_stream(input logic [31:0] start);
    fetch_entry_t e;
    expq.delete();
    for (int i = 0; i < 64; i++) begin
      e.pc         = start + 32'(4 * i);
      e.instr      = mem_word(e.pc);
      e.misaligned = 1'b0;
      expq.push_back(e);
    end
  endfunction

  // Memory: one response per accepted request, 1 + extra_delay cycles later.
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (resp_cnt == 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(resp_addr);
        resp_cnt        = 0;
      end else begin
        imem_resp_valid = 1'b0;
        if (resp_cnt > 1) resp_cnt--;
      end
      #2;
      if (imem_req_valid && imem_req_ready) begin
        resp_addr = imem_req_addr;
        resp_cnt  = 1 + extra_delay;
      end
    end
  end

  // Scoreboard: every entry decode consumes must be the next expected one.
  initial begin
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      #3;
      if (if_valid === 1'b1 && if_ready === 1'b1) begin
        tests_run++;
        pop_count++;
        if (expq.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL sb_unexpected: got pc=%h instr=%h, expected no entry", if_pc, if_instr);
        end else begin
          e = expq.pop_front();
          if (if_pc !== e.pc || if_instr !== e.instr || if_misaligned !== e.misaligned) begin
            tests_failed++;
            $display("[TB] FAIL sb_entry: got pc=%h instr=%h mis=%b, expected pc=%h instr=%h mis=%b",
                     if_pc, if_instr, if_misaligned, e.pc, e.instr, e.misaligned);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (pc !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_pc: got %h, expected 0", pc); end
    tests_run++;
    if (imem_req_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_req_valid: got %b, expected 0", imem_req_valid); end
    tests_run++;
    if (if_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_if_valid: got %b, expected 0", if_valid); end
    tests_run++;
    if (if_pc !== 32'h0 || if_instr !== 32'h0 || if_misaligned !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_head: got pc=%h instr=%h mis=%b, expected zeros", if_pc, if_instr, if_misaligned);
    end
  endtask

  task automatic test_sequential();
    int base;
    set_stream(32'h0);
    base = pop_count;
    @(negedge clk);
    reset    = 1'b0;
    if_ready = 1'b1;
    #1;
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL seq_first_req: got valid=%b addr=%h, expected 1/0", imem_req_valid, imem_req_addr);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || pc !== 32'h4) begin
      tests_failed++;
      $display("[TB] FAIL seq_wait: got req=%b if_valid=%b pc=%h, expected 0/0/4", imem_req_valid, if_valid, pc);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL seq_latency: got if_valid=%b if_pc=%h, expected 1/0", if_valid, if_pc);
    end
    for (int c = 0; c < 40 && pop_count < base + 4; c++) @(negedge clk);
    tests_run++;
    if (pop_count < base + 4) begin
      tests_failed++;
      $display("[TB] FAIL seq_progress: got %0d pops, expected %0d", pop_count - base, 4);
    end
  endtask

  task automatic test_fill();
    int base;
    @(negedge clk);
    if_ready = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    tests_run++;
    if (imem_req_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_req_valid: got %b, expected 0", imem_req_valid); end
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== expq[0].pc) begin
      tests_failed++;
      $display("[TB] FAIL fill_head: got valid=%b pc=%h, expected 1/%h", if_valid, if_pc, expq[0].pc);
    end
    tests_run++;
    if (pc !== expq[0].pc + 32'd8) begin
      tests_failed++;
      $display("[TB] FAIL fill_pc: got %h, expected %h", pc, expq[0].pc + 32'd8);
    end
    base = pop_count;
    @(negedge clk);
    if_ready = 1'b1;
    for (int c = 0; c < 40 && pop_count < base + 4; c++) @(negedge clk);
    tests_run++;
    if (pop_count < base + 4) begin
      tests_failed++;
      $display("[TB] FAIL fill_progress: got %0d pops, expected %0d", pop_count - base, 4);
    end
  endtask

  task automatic test_stall();
    int base;
    @(negedge clk);
    redirect     = 1'b1;
    redir_target = 32'h10;
    set_stream(32'h10);
    @(negedge clk);
    redirect = 1'b0;
    pc_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (imem_req_valid !== 1'b0 || pc !== 32'h10) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold: got req=%b pc=%h, expected 0/10", imem_req_valid, pc);
      end
      @(negedge clk);
    end
    pc_stall = 1'b0;
    base = pop_count;
    #1;
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
      tests_failed++;
      $display("[TB] FAIL stall_resume: got valid=%b addr=%h, expected 1/10", imem_req_valid, imem_req_addr);
    end
    for (int c = 0; c < 30 && pop_count < base + 2; c++) @(negedge clk);
    tests_run++;
    if (pop_count < base + 2) begin
      tests_failed++;
      $display("[TB] FAIL stall_progress: got %0d pops, expected %0d", pop_count - base, 2);
    end
  endtask

  task automatic test_redirect_wait();
    int base;
    bit found = 1'b0;
    extra_delay = 1;
    @(negedge clk);
    redirect     = 1'b1;
    redir_target = 32'h20;
    set_stream(32'h20);
    @(negedge clk);
    redirect = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      #1;
      if (imem_req_valid && imem_req_ready && imem_req_addr == 32'h20) found = 1'b1;
      else @(negedge clk);
    end
    tests_run++;
    if (!found) begin tests_failed++; $display("[TB] FAIL rw_fire: got no request, expected fetch of 20"); end
    @(negedge clk);
    redirect     = 1'b1;
    redir_target = 32'hDEAD_0000;
    set_stream(32'hDEAD_0000);
    #1;
    tests_run++;
    if (if_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rw_if_valid: got %b, expected 0", if_valid); end
    @(negedge clk);
    redirect    = 1'b0;
    extra_delay = 0;
    base        = pop_count;
    #1;
    tests_run++;
    if (pc !== 32'hDEAD_0000) begin tests_failed++; $display("[TB] FAIL rw_pc: got %h, expected dead0000", pc); end
    for (int c = 0; c < 30 && pop_count < base + 2; c++) @(negedge clk);
    tests_run++;
    if (pop_count < base + 2) begin
      tests_failed++;
      $display("[TB] FAIL rw_progress: got %0d pops, expected %0d", pop_count - base, 2);
    end
  endtask

  task automatic test_redirect_resp();
    int base;
    bit found = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 20 && !found; c++) begin
      #1;
      if (imem_req_valid && imem_req_ready) found = 1'b1;
      else @(negedge clk);
    end
    tests_run++;
    if (!found) begin tests_failed++; $display("[TB] FAIL rr_fire: got no request, expected one"); end
    @(negedge clk);
    redirect     = 1'b1;
    redir_target = 32'h0000_4000;
    set_stream(32'h0000_4000);
    @(negedge clk);
    redirect = 1'b0;
    base     = pop_count;
    #1;
    tests_run++;
    if (pc !== 32'h4000 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4000) begin
      tests_failed++;
      $display("[TB] FAIL rr_next_req: got pc=%h valid=%b addr=%h, expected 4000/1/4000", pc, imem_req_valid, imem_req_addr);
    end
    for (int c = 0; c < 30 && pop_count < base + 2; c++) @(negedge clk);
    tests_run++;
    if (pop_count < base + 2) begin
      tests_failed++;
      $display("[TB] FAIL rr_progress: got %0d pops, expected %0d", pop_count - base, 2);
    end
  endtask

  task automatic test_redirect_fire();
    int base;
    bit found = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 20 && !found; c++) begin
      #1;
      if (imem_req_valid && imem_req_ready) found = 1'b1;
      else @(negedge clk);
    end
    tests_run++;
    if (!found) begin tests_failed++; $display("[TB] FAIL rf_fire: got no request, expected one"); end
    redirect     = 1'b1;
    redir_target = 32'h0000_5000;
    set_stream(32'h0000_5000);
    @(negedge clk);
    redirect = 1'b0;
    base     = pop_count;
    #1;
    tests_run++;
    if (pc !== 32'h5000 || imem_req_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rf_drain: got pc=%h valid=%b, expected 5000/0", pc, imem_req_valid);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h5000) begin
      tests_failed++;
      $display("[TB] FAIL rf_next_req: got valid=%b addr=%h, expected 1/5000", imem_req_valid, imem_req_addr);
    end
    for (int c = 0; c < 30 && pop_count < base + 2; c++) @(negedge clk);
    tests_run++;
    if (pop_count < base + 2) begin
      tests_failed++;
      $display("[TB] FAIL rf_progress: got %0d pops, expected %0d", pop_count - base, 2);
    end
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misaligned();
    int base;
    fetch_entry_t e;
    @(negedge clk);
    redirect     = 1'b1;
    redir_target = 32'hCAFE_BABE;
    expq.delete();
    e.pc         = 32'hCAFE_BABE;
    e.instr      = 32'h0000_0013;
    e.misaligned = 1'b1;
    expq.push_back(e);
    base = pop_count;
    @(negedge clk);
    redirect = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      tests_run++;
      if (imem_req_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL mis_no_req: got %b, expected 0", imem_req_valid);
      end
      @(negedge clk);
    end
    tests_run++;
    if (pop_count != base + 1 || pc !== 32'hCAFE_BABE) begin
      tests_failed++;
      $display("[TB] FAIL mis_fault: got %0d pops pc=%h, expected 1/cafebabe", pop_count - base, pc);
    end
  endtask
`else
  task automatic test_misaligned();
    int base;
    bit found = 1'b0;
    @(negedge clk);
    redirect     = 1'b1;
    redir_target = 32'h0000_0102;
    set_stream(32'h0000_0102);
    base = pop_count;
    @(negedge clk);
    redirect = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      #1;
      if (imem_req_valid && imem_req_ready) found = 1'b1;
      else @(negedge clk);
    end
    tests_run++;
    if (!found || imem_req_addr !== 32'h100) begin
      tests_failed++;
      $display("[TB] FAIL unaligned_addr: got found=%b addr=%h, expected 1/100", found, imem_req_addr);
    end
    for (int c = 0; c < 30 && pop_count < base + 2; c++) @(negedge clk);
    tests_run++;
    if (pop_count < base + 2) begin
      tests_failed++;
      $display("[TB] FAIL unaligned_progress: got %0d pops, expected %0d", pop_count - base, 2);
    end
  endtask
`endif

  initial begin
    reset          = 1'b1;
    redirect       = 1'b0;
    redir_target   = '0;
    pc_stall       = 1'b0;
    imem_req_ready = 1'b1;
    if_ready       = 1'b0;
    test_reset();
    test_sequential();
    test_fill();
    test_stall();
    test_redirect_wait();
    test_redirect_resp();
    test_redirect_fire();
    test_misaligned();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
